// File: rtl/unet_pkg.sv
// unet_pkg: shared phase encoding, transfer sizes and counter widths for the U-Net control shell
package unet_pkg;
    localparam int N_WEIGHTS = 939;
    localparam int N_INPUT   = 98369;
    localparam int N_OUTPUT  = 65536;
    localparam int WCNT_W    = 10;
    localparam int DCNT_W    = 17;
    localparam int RCNT_W    = 16;
    typedef enum logic [2:0] {
        CALCULATING  = 3'd0,
        SEND_WEIGHTS = 3'd1,
        SEND_DATA    = 3'd2,
        DATA_READY   = 3'd3,
        SENDING      = 3'd4,
        IDLE         = 3'd5
    } ctrl_e;
endpackage

// File: rtl/unet_engine.sv
// unet_engine: compute engine stand-in behind the control shell
// Ports: clk/rst (async, active-high); w_we/w_addr/w_data weight writes;
//   d_we/d_addr/d_data input writes; start -> done after DONE_LAT cycles;
//   r_addr -> r_data with one cycle of read latency.
// Results are r_addr ^ 0xA5A5A5A5 folded with running XOR checksums of the
// weight and input streams (each word XORed with its address), so a corrupted
// or misordered load shows up in the readout.
module unet_engine #(
    parameter int DONE_LAT = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        w_we,
    input  logic [9:0]  w_addr,
    input  logic [31:0] w_data,
    input  logic        d_we,
    input  logic [16:0] d_addr,
    input  logic [31:0] d_data,
    input  logic        start,
    output logic        done,
    input  logic [15:0] r_addr,
    output logic [31:0] r_data
);
    logic [31:0] wsum_q, dsum_q, r_data_q;
    logic [15:0] timer_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wsum_q   <= '0;
            dsum_q   <= '0;
            r_data_q <= '0;
            timer_q  <= '0;
        end else begin
            // address 0 opens a new load, so the checksum restarts there
            if (w_we) wsum_q <= (w_addr == '0 ? '0 : wsum_q) ^ w_data ^ {22'd0, w_addr};
            if (d_we) dsum_q <= (d_addr == '0 ? '0 : dsum_q) ^ d_data ^ {15'd0, d_addr};
            timer_q  <= start ? 16'(DONE_LAT) : (timer_q != '0 ? timer_q - 16'd1 : timer_q);
            r_data_q <= {16'd0, r_addr} ^ 32'hA5A5A5A5 ^ wsum_q ^ dsum_q;
        end
    end
    assign done   = timer_q == 16'd1;
    assign r_data = r_data_q;
endmodule

// File: rtl/unet_top_core.sv
// unet_top_core: phase sequencer moving host words to/from the U-Net engine
// Ports: clk; rst_n (async, active-high despite the name); unet_enpulse phase
//   advance request; data_in weight/input stream; ctrl phase code;
//   busy high while a phase is in progress; data_out result stream.
module unet_top_core
    import unet_pkg::*;
#(
    parameter int N_W        = N_WEIGHTS,
    parameter int N_I        = N_INPUT,
    parameter int N_O        = N_OUTPUT,
    parameter int ENGINE_LAT = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        unet_enpulse,
    input  logic [31:0] data_in,
    output logic [2:0]  ctrl,
    output logic        busy,
    output logic [31:0] data_out
);
    ctrl_e              state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [RCNT_W-1:0]  rcnt_q, rcnt_d, r_addr;
    logic               wl_q, wl_d, start_q, start_d, engine_done;
    logic [31:0]        dout_q, dout_d, r_data;
    logic               w_last, d_last, r_last;

    assign w_last = wcnt_q == WCNT_W'(N_W - 1);
    assign d_last = dcnt_q == DCNT_W'(N_I - 1);
    assign r_last = rcnt_q == RCNT_W'(N_O - 1);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            wl_q    <= 1'b0;
            start_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            wl_q    <= wl_d;
            start_q <= start_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (unet_enpulse) state_d = wl_q ? SEND_DATA : SEND_WEIGHTS;
            SEND_WEIGHTS: if (w_last) state_d = IDLE;
            SEND_DATA:    if (d_last) state_d = CALCULATING;
            CALCULATING:  if (engine_done && !start_q) state_d = DATA_READY;
            DATA_READY:   if (unet_enpulse) state_d = SENDING;
            SENDING:      if (r_last) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    // Readout runs two ahead of data_out (engine register + output register):
    // word 0 is requested until the advance pulse, word 1 during it, then rcnt+2.
    always_comb begin
        wcnt_d  = state_q == SEND_WEIGHTS ? wcnt_q + WCNT_W'(1) : '0;
        dcnt_d  = state_q == SEND_DATA ? dcnt_q + DCNT_W'(1) : '0;
        rcnt_d  = state_q == SENDING ? rcnt_q + RCNT_W'(1) : '0;
        wl_d    = wl_q | (state_q == SEND_WEIGHTS && w_last);
        start_d = state_q == SEND_DATA && d_last;
        dout_d  = (state_q == DATA_READY || (state_q == SENDING && !r_last)) ? r_data : dout_q;
        r_addr  = state_q == SENDING ? rcnt_q + RCNT_W'(2) :
                  (state_q == DATA_READY && unet_enpulse) ? RCNT_W'(1) : '0;
    end

    always_comb begin
        ctrl     = state_q;
        busy     = state_q inside {SEND_WEIGHTS, SEND_DATA, CALCULATING, SENDING};
        data_out = dout_q;
    end

    unet_engine #(.DONE_LAT(ENGINE_LAT)) u_eng (
        .clk    (clk),
        .rst    (rst_n),
        .w_we   (state_q == SEND_WEIGHTS),
        .w_addr (wcnt_q),
        .w_data (data_in),
        .d_we   (state_q == SEND_DATA),
        .d_addr (dcnt_q),
        .d_data (data_in),
        .start  (start_q),
        .done   (engine_done),
        .r_addr (r_addr),
        .r_data (r_data)
    );
endmodule

// File: tb/tb_unet_top_core.sv
// tb_unet_top_core: scoreboard bench for the U-Net control shell
module tb_unet_top_core;
    localparam int NW = 939;
    localparam int NI = 200;
    localparam int NO = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        unet_enpulse = 1'b0;
    logic [31:0] data_in = '0;
    logic [2:0]  ctrl;
    logic        busy;
    logic [31:0] data_out;

    int n_chk = 0, n_fail = 0, n_start = 0, exp_start = 0, rcyc = 0;
    logic [31:0] wsum = '0, dsum = '0;
    logic [50:0] wq[$];
    logic [31:0] rq[$];

    unet_top_core #(.N_W(NW), .N_I(NI), .N_O(NO), .ENGINE_LAT(100)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .unet_enpulse (unet_enpulse),
        .data_in      (data_in),
        .ctrl         (ctrl),
        .busy         (busy),
        .data_out     (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (u_dut.u_eng.start) n_start++;
        if (u_dut.u_eng.w_we || u_dut.u_eng.d_we) begin
            if (wq.size() == 0) chk("wr_unexpected", 1, 0);
            else chk("wr_stream",
                     {u_dut.u_eng.d_we, u_dut.u_eng.w_we,
                      u_dut.u_eng.w_we ? {7'd0, u_dut.u_eng.w_addr} : u_dut.u_eng.d_addr,
                      u_dut.u_eng.w_we ? u_dut.u_eng.w_data : u_dut.u_eng.d_data},
                     wq.pop_front());
        end
        if (ctrl == 3'd4) begin
            rcyc++;
            if (rq.size() == 0) chk("rd_extra", 1, 0);
            else chk("rd_word", data_out, rq.pop_front());
        end
    end

    task automatic stream(input int n, input bit wgt, input logic [2:0] after);
        int cyc = 0;
        logic [31:0] v;
        for (int k = 0; k < n; k++) begin
            v = $urandom;
            data_in = v;
            unet_enpulse = (k < 2) || (k >= 50 && k < 60);
            wq.push_back({!wgt, wgt, 17'(k), v});
            if (wgt) wsum ^= v ^ 32'(k);
            else dsum ^= v ^ 32'(k);
            if (ctrl == (wgt ? 3'd1 : 3'd2) && busy) cyc++;
            @(posedge clk); #1;
        end
        unet_enpulse = 1'b0;
        chk(wgt ? "w_cycles" : "d_cycles", cyc, n);
        chk("ctrl_after_load", ctrl, after);
    endtask

    task automatic infer();
        logic [31:0] last;
        dsum = '0;
        unet_enpulse = 1'b1;
        @(posedge clk); #1;
        chk("enter_send_data", ctrl, 2);
        stream(NI, 1'b0, 3'd0);
        exp_start++;
        for (int i = 0; i < 1000 && ctrl != 3'd3; i++) begin
            unet_enpulse = i < 20;
            @(posedge clk); #1;
        end
        unet_enpulse = 1'b0;
        chk("done_to_ready", ctrl, 3);
        chk("busy_ready", busy, 0);
        chk("start_pulses", n_start, exp_start);
        for (int k = 0; k < NO; k++) rq.push_back({16'd0, 16'(k)} ^ 32'hA5A5A5A5 ^ wsum ^ dsum);
        last = rq[NO-1];
        @(posedge clk); #1;
        chk("prefetch", data_out, rq[0]);
        rcyc = 0;
        unet_enpulse = 1'b1;
        @(posedge clk); #1;
        unet_enpulse = 1'b0;
        chk("enter_sending", ctrl, 4);
        chk("busy_sending", busy, 1);
        for (int i = 0; i < NO + 20 && ctrl == 3'd4; i++) begin
            @(posedge clk); #1;
        end
        chk("rd_cycles", rcyc, NO);
        chk("rd_left", rq.size(), 0);
        chk("idle_after_rd", ctrl, 5);
        repeat (3) @(posedge clk);
        #1;
        chk("dout_hold", data_out, last);
    endtask

    initial begin
        #1 rst_n = 1'b1;
        #1;
        chk("rst_ctrl", ctrl, 5);
        chk("rst_busy", busy, 0);
        chk("rst_dout", data_out, 0);
        #10 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("idle_hold", ctrl, 5);
        unet_enpulse = 1'b1;
        @(posedge clk); #1;
        chk("enter_weights", ctrl, 1);
        chk("busy_weights", busy, 1);
        stream(NW, 1'b1, 3'd5);
        infer();
        infer();
        dsum = '0;
        unet_enpulse = 1'b1;
        @(posedge clk); #1;
        chk("reenter_data", ctrl, 2);
        stream(10, 1'b0, 3'd2);
        #2 rst_n = 1'b1;
        #1;
        chk("async_rst_ctrl", ctrl, 5);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_dout", data_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        chk("rst_hold", ctrl, 5);
        unet_enpulse = 1'b1;
        @(posedge clk); #1;
        unet_enpulse = 1'b0;
        chk("reload_weights", ctrl, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
